color_threshold_mask: RTL and testbench
=======================================

# color_threshold_mask

Converts the RGB frame held in pixel memory into a binary mask in place, one word per pixel, so the edge-filling stages that follow (the Y-direction pixel filler is the next stage) see the value 1 for "object colour" and 0 otherwise. It walks the whole 320x240 frame sequentially on the shared memory bus, compares each pixel's channels against programmable inclusive ranges, writes the mask word back to the same address, counts set pixels, and raises a done flag. It owns the bus only while enabled and releases it (high-Z) otherwise.

## Interface
- IMAGE_WIDTH, 320, pixels per line
- IMAGE_HEIGHT, 240, lines per frame
- BORDER_LINES, 7, lines at top and at bottom forced to 0 (sensor garbage)
- clk_div_by_two  in  1  stage clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- enable_color_threshold  in  1  sequencer grant; high = own bus and run
- data_read  in  32  memory read data; valid on the edge after address is presented
- red_min, red_max, green_min, green_max, blue_min, blue_max  in  8 each  inclusive channel limits; held stable while enabled
- wren  out  1  memory write enable (high-Z when not enabled)
- data_write  out  32  mask word: 32'd1 or 32'd0 (high-Z when not enabled)
- address  out  18  memory word address (high-Z when not enabled)
- color_threshold_done  out  1  frame complete
- set_pixel_count  out  17  number of pixels written as 1 in the last/current pass

## Operation
- Pixel word: [23:16] red, [15:8] green, [7:0] blue; [31:24] ignored.
- Match = all three channels within [min,max] inclusive; min>max on any channel means no match.
- Rows 0..BORDER_LINES-1 and IMAGE_HEIGHT-BORDER_LINES..IMAGE_HEIGHT-1 (addresses 0..2239, 74560..76799): written 0 without regard to data.
- States: IDLE -> ADDR -> CAPTURE -> WRITE -> (ADDR | DONE).
- IDLE: pointer p=0, count=0, done=0; on enable go ADDR.
- ADDR: address=p, wren=0.
- CAPTURE: register data_read, evaluate match, address still p, wren=0.
- WRITE: address=p, data_write=mask, wren=1; count += mask; if p==IMAGE_WIDTH*IMAGE_HEIGHT-1 go DONE else p+=1, go ADDR.
- DONE: wren=0, done=1, count held; stay while enable high.
- enable low in any state: bus outputs high-Z, done=0, state IDLE; a later enable restarts at address 0 and clears count. Count value remains readable in IDLE until next start.
- reset high: state IDLE, p=0, set_pixel_count=0, done=0, bus outputs high-Z, regardless of enable. Reset dominates enable in the same cycle.

## Timing
- 3 cycles per pixel; first write at cycle 3 after enable sampled high (cycle 1 = ADDR); done asserts 3*76800+1 = 230401 cycles after enable sampled, then holds.
- Read latency fixed at one cycle: data captured in CAPTURE belongs to address driven in ADDR.
- wren high exactly one cycle per pixel; address never changes while wren high.
- Outputs registered; no combinational path from data_read to wren/address.
- Count is 17 bits; max value 76800-2*7*320=72320, no overflow; no saturation logic needed.

## Structure
- Shared package falcon_image_pkg: IMAGE_WIDTH, IMAGE_HEIGHT, FRAME_WORDS (76800), BORDER_LINES, address width 18, channel bit positions, state encoding for this block.
- Sub-module channel_range_compare: one 8-bit value vs min/max, combinational, instantiated three times.
- Border test by address compare against precomputed constants (2240, 74560), not by row counter.

## Test plan
- Frame filled with 32'h00FF0000, limits red 200..255, green/blue 0..10 -> rows 7..232 read back 1, border rows 0, set_pixel_count=72320, done after 230401 cycles.
- Single matching pixel at address 5000, rest 32'h00000000 with limits excluding 0 -> only address 5000 is 1, count=1.
- Pixel exactly at limits (red=red_min, green=green_max) -> 1; red=red_min-1 -> 0; red_min=10, red_max=5 -> all 0.
- Matching pixel at address 2239 and 74560 -> both written 0; at 2240 and 74559 -> written 1.
- Drop enable at pixel 1000 -> next cycle address/data_write/wren high-Z, done 0; re-enable -> first address 0, count restarts from 0.
- Assert reset mid-frame with enable high -> bus high-Z, count 0, done 0 next edge; release reset -> pass restarts at address 0.

Source files
------------

// File: rtl/falcon_image_pkg.sv
`default_nettype none
// ============================================================================
// Package     : falcon_image_pkg
// Description : Frame geometry, bus widths, pixel channel positions and the
//               state encoding shared by the colour-threshold stage.
// Revision    : 1.0 - initial release
// ============================================================================
package falcon_image_pkg;

  localparam int IMAGE_WIDTH  = 320;
  localparam int IMAGE_HEIGHT = 240;
  localparam int FRAME_WORDS  = IMAGE_WIDTH * IMAGE_HEIGHT;  // 76800
  localparam int BORDER_LINES = 7;

  localparam int ADDR_W    = 18;
  localparam int DATA_W    = 32;
  localparam int COUNT_W   = 17;
  localparam int CHANNEL_W = 8;

  // Channel positions inside a pixel word; bits [31:24] carry no colour.
  localparam int RED_LSB   = 16;
  localparam int GREEN_LSB = 8;
  localparam int BLUE_LSB  = 0;

  typedef enum logic [2:0] {
    CT_IDLE    = 3'd0,
    CT_ADDR    = 3'd1,
    CT_CAPTURE = 3'd2,
    CT_WRITE   = 3'd3,
    CT_DONE    = 3'd4
  } ct_state_e;

endpackage
`default_nettype wire

// File: rtl/channel_range_compare.sv
`default_nettype none
// ============================================================================
// Module      : channel_range_compare
// Description : Inclusive range test of one 8-bit colour channel. A window
//               with min above max can never be satisfied.
// Revision    : 1.0 - initial release
// ============================================================================
module channel_range_compare
  import falcon_image_pkg::*;
(
  input  logic [CHANNEL_W-1:0] value,
  input  logic [CHANNEL_W-1:0] min_val,
  input  logic [CHANNEL_W-1:0] max_val,
  output logic                 in_range
);

  // Both bounds inclusive; an inverted window fails one of the two tests.
  assign in_range = (value >= min_val) && (value <= max_val);

endmodule
`default_nettype wire

// File: rtl/color_threshold_mask.sv
`default_nettype none
// ============================================================================
// Module      : color_threshold_mask
// Description : Walks the frame in pixel memory, replaces each RGB word with
//               a 0/1 mask word in place, counts set pixels and flags done.
//               Drives the shared bus only while the sequencer grants it.
// Revision    : 1.0 - initial release
// ============================================================================
module color_threshold_mask
  import falcon_image_pkg::*;
#(
  parameter int IMAGE_WIDTH  = falcon_image_pkg::IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = falcon_image_pkg::IMAGE_HEIGHT,
  parameter int BORDER_LINES = falcon_image_pkg::BORDER_LINES
) (
  input  logic                 clk_div_by_two,
  input  logic                 reset,
  input  logic                 enable_color_threshold,
  input  logic [DATA_W-1:0]    data_read,
  input  logic [CHANNEL_W-1:0] red_min,
  input  logic [CHANNEL_W-1:0] red_max,
  input  logic [CHANNEL_W-1:0] green_min,
  input  logic [CHANNEL_W-1:0] green_max,
  input  logic [CHANNEL_W-1:0] blue_min,
  input  logic [CHANNEL_W-1:0] blue_max,
  output wire logic               wren,
  output wire logic [DATA_W-1:0]  data_write,
  output wire logic [ADDR_W-1:0]  address,
  output logic                 color_threshold_done,
  output logic [COUNT_W-1:0]   set_pixel_count
);

  // Border rows are recognised by address alone, not by a row counter.
  localparam logic [ADDR_W-1:0] LAST_ADDR        = ADDR_W'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] BORDER_TOP_END   = ADDR_W'(IMAGE_WIDTH * BORDER_LINES);
  localparam logic [ADDR_W-1:0] BORDER_BOT_START = ADDR_W'(IMAGE_WIDTH * (IMAGE_HEIGHT - BORDER_LINES));

  ct_state_e            state;
  logic                 bus_own;
  logic [ADDR_W-1:0]    addr_reg;
  logic                 wren_reg;
  logic [DATA_W-1:0]    data_reg;

  logic                 red_ok;
  logic                 green_ok;
  logic                 blue_ok;
  logic                 in_border;
  logic                 pixel_mask;
  logic                 unused_alpha;

  channel_range_compare u_red (
    .value    (data_read[RED_LSB +: CHANNEL_W]),
    .min_val  (red_min),
    .max_val  (red_max),
    .in_range (red_ok)
  );

  channel_range_compare u_green (
    .value    (data_read[GREEN_LSB +: CHANNEL_W]),
    .min_val  (green_min),
    .max_val  (green_max),
    .in_range (green_ok)
  );

  channel_range_compare u_blue (
    .value    (data_read[BLUE_LSB +: CHANNEL_W]),
    .min_val  (blue_min),
    .max_val  (blue_max),
    .in_range (blue_ok)
  );

  // The top byte of a pixel word carries nothing of interest.
  assign unused_alpha = ^data_read[DATA_W-1:24];

  assign in_border  = (addr_reg < BORDER_TOP_END) || (addr_reg >= BORDER_BOT_START);
  assign pixel_mask = red_ok && green_ok && blue_ok && !in_border;

  // Bus is released whenever the registered ownership flag is low.
  assign wren       = bus_own ? wren_reg : 1'bz;
  assign data_write = bus_own ? data_reg : {DATA_W{1'bz}};
  assign address    = bus_own ? addr_reg : {ADDR_W{1'bz}};

  // Sequencer: ADDR presents the word, CAPTURE samples it one cycle later,
  // WRITE stores the mask to the same address and accumulates the count.
  always_ff @(posedge clk_div_by_two) begin
    if (reset) begin
      state                <= CT_IDLE;
      bus_own              <= 1'b0;
      addr_reg             <= '0;
      wren_reg             <= 1'b0;
      data_reg             <= '0;
      set_pixel_count      <= '0;
      color_threshold_done <= 1'b0;
    end else if (!enable_color_threshold) begin
      // Count is deliberately kept so it stays readable until the next pass.
      state                <= CT_IDLE;
      bus_own              <= 1'b0;
      wren_reg             <= 1'b0;
      color_threshold_done <= 1'b0;
    end else begin
      bus_own <= 1'b1;
      case (state)
        CT_IDLE: begin
          addr_reg             <= '0;
          wren_reg             <= 1'b0;
          set_pixel_count      <= '0;
          color_threshold_done <= 1'b0;
          state                <= CT_ADDR;
        end
        CT_ADDR: begin
          wren_reg <= 1'b0;
          state    <= CT_CAPTURE;
        end
        CT_CAPTURE: begin
          data_reg <= {{(DATA_W-1){1'b0}}, pixel_mask};
          wren_reg <= 1'b1;
          state    <= CT_WRITE;
        end
        CT_WRITE: begin
          wren_reg        <= 1'b0;
          set_pixel_count <= set_pixel_count + COUNT_W'(data_reg[0]);
          if (addr_reg == LAST_ADDR) begin
            color_threshold_done <= 1'b1;
            state                <= CT_DONE;
          end else begin
            addr_reg <= addr_reg + ADDR_W'(1);
            state    <= CT_ADDR;
          end
        end
        CT_DONE: begin
          wren_reg             <= 1'b0;
          color_threshold_done <= 1'b1;
        end
        default: begin
          wren_reg <= 1'b0;
          state    <= CT_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_color_threshold_mask.sv
`default_nettype none
// ============================================================================
// Module      : tb_color_threshold_mask
// Description : Self-checking bench for color_threshold_mask on a reduced
//               16x12 frame with 2 border lines.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_color_threshold_mask;

  localparam int W         = 16;
  localparam int H         = 12;
  localparam int B         = 2;
  localparam int F         = W * H;
  localparam int TOP_END   = W * B;
  localparam int BOT_START = W * (H - B);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] data_read = 32'h0;
  logic [7:0]  rmin = 8'd0, rmax = 8'd0, gmin = 8'd0, gmax = 8'd0, bmin = 8'd0, bmax = 8'd0;
  tri1         wren;
  tri1 [31:0]  data_write;
  tri1 [17:0]  address;
  logic        done;
  logic [16:0] count;

  logic [31:0] img [F];
  logic [31:0] got [F];

  int compared = 0;
  int mismatched = 0;

  color_threshold_mask #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .BORDER_LINES (B)
  ) dut (
    .clk_div_by_two         (clk),
    .reset                  (reset),
    .enable_color_threshold (enable),
    .data_read              (data_read),
    .red_min                (rmin),
    .red_max                (rmax),
    .green_min              (gmin),
    .green_max              (gmax),
    .blue_min               (bmin),
    .blue_max               (bmax),
    .wren                   (wren),
    .data_write             (data_write),
    .address                (address),
    .color_threshold_done   (done),
    .set_pixel_count        (count)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: data follows the address by one edge.
  always @(posedge clk) data_read <= (address < 18'(F)) ? img[int'(address)] : 32'h0;

  function automatic bit ref_mask(input logic [31:0] px, input int idx);
    int r, g, b;
    if (idx < TOP_END || idx >= BOT_START) return 1'b0;
    r = int'(px[23:16]);
    g = int'(px[15:8]);
    b = int'(px[7:0]);
    return (r >= int'(rmin)) && (r <= int'(rmax)) &&
           (g >= int'(gmin)) && (g <= int'(gmax)) &&
           (b >= int'(bmin)) && (b <= int'(bmax));
  endfunction

  function automatic int ref_count(input int upto);
    int s = 0;
    for (int i = 0; i < upto; i++) s += int'(ref_mask(img[i], i));
    return s;
  endfunction

  task automatic set_limits(input logic [7:0] rl, rh, gl, gh, bl, bh);
    rmin = rl; rmax = rh; gmin = gl; gmax = gh; bmin = bl; bmax = bh;
  endtask

  task automatic check_released(input string tag);
    compared++;
    if (wren !== 1'b1 || address !== 18'h3FFFF || data_write !== 32'hFFFFFFFF) begin
      mismatched++;
      $display("FAIL %s released bus: got wren=%b addr=%h data=%h required all-high pull", tag, wren, address, data_write);
    end
  endtask

  // Runs one complete pass from IDLE and checks timing, protocol and results.
  task automatic run_frame(input string tag);
    int  n, first_wr, writes, done_at, exp_cnt;
    bit  prev_wren, proto_bad;
    for (int i = 0; i < F; i++) got[i] = 32'hDEADBEEF;
    n = 0; first_wr = -1; writes = 0; done_at = -1; prev_wren = 1'b0; proto_bad = 1'b0;
    @(negedge clk); reset = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3 * F + 20; i++) begin
      @(posedge clk); #1; n++;
      if (wren === 1'b1) begin
        if (first_wr < 0) first_wr = n;
        if (prev_wren) proto_bad = 1'b1;
        if (address !== 18'(writes)) proto_bad = 1'b1;
        if (address < 18'(F)) got[int'(address)] = data_write;
        writes++;
      end
      prev_wren = (wren === 1'b1);
      if (done === 1'b1 && done_at < 0) done_at = n;
      if (done_at >= 0 && n >= done_at + 3) break;
    end
    compared++;
    if (first_wr != 3) begin mismatched++; $display("FAIL %s first_write_cycle: got %0d required 3", tag, first_wr); end
    compared++;
    if (done_at != 3 * F + 1) begin mismatched++; $display("FAIL %s done_cycle: got %0d required %0d", tag, done_at, 3 * F + 1); end
    compared++;
    if (writes != F) begin mismatched++; $display("FAIL %s write_count: got %0d required %0d", tag, writes, F); end
    compared++;
    if (proto_bad) begin mismatched++; $display("FAIL %s write_protocol: got violation required sequential single-cycle writes", tag); end
    compared++;
    if (done !== 1'b1) begin mismatched++; $display("FAIL %s done_hold: got %b required 1", tag, done); end
    exp_cnt = ref_count(F);
    compared++;
    if (count !== 17'(exp_cnt)) begin mismatched++; $display("FAIL %s set_pixel_count: got %0d required %0d", tag, count, exp_cnt); end
    for (int i = 0; i < F; i++) begin
      compared++;
      if (got[i] !== {31'd0, ref_mask(img[i], i)}) begin
        mismatched++;
        $display("FAIL %s pixel[%0d]: got %h required %h", tag, i, got[i], {31'd0, ref_mask(img[i], i)});
      end
    end
    @(negedge clk); enable = 1'b0;
    @(posedge clk); #1;
    check_released({tag, " after_disable"});
    compared++;
    if (done !== 1'b0) begin mismatched++; $display("FAIL %s done_after_disable: got %b required 0", tag, done); end
    compared++;
    if (count !== 17'(exp_cnt)) begin mismatched++; $display("FAIL %s count_held_idle: got %0d required %0d", tag, count, exp_cnt); end
  endtask

  // Waits (bounded) for the write strobe at a given pixel address.
  task automatic wait_write(input string tag, input int target);
    bit hit = 1'b0;
    for (int i = 0; i < 3 * F + 10; i++) begin
      @(posedge clk); #1;
      if (wren === 1'b1 && address === 18'(target)) begin hit = 1'b1; break; end
    end
    compared++;
    if (!hit) begin mismatched++; $display("FAIL %s reach_pixel_%0d: got timeout required write strobe", tag, target); end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_released("reset");
    compared++;
    if (done !== 1'b0) begin mismatched++; $display("FAIL reset done: got %b required 0", done); end
    compared++;
    if (count !== 17'd0) begin mismatched++; $display("FAIL reset count: got %0d required 0", count); end
    @(negedge clk); enable = 1'b0;
  endtask

  task automatic test_solid();
    for (int i = 0; i < F; i++) img[i] = 32'h00FF0000;
    set_limits(8'd200, 8'd255, 8'd0, 8'd10, 8'd0, 8'd10);
    run_frame("solid");
    compared++;
    if (count !== 17'(F - 2 * TOP_END)) begin mismatched++; $display("FAIL solid interior_count: got %0d required %0d", count, F - 2 * TOP_END); end
  endtask

  task automatic test_single();
    for (int i = 0; i < F; i++) img[i] = 32'h0;
    img[100] = 32'h00804020;
    set_limits(8'h70, 8'h90, 8'h30, 8'h50, 8'h10, 8'h30);
    run_frame("single");
    compared++;
    if (count !== 17'd1 || got[100] !== 32'd1) begin mismatched++; $display("FAIL single pixel100: got count=%0d word=%h required 1/1", count, got[100]); end
  endtask

  task automatic test_limits();
    for (int i = 0; i < F; i++) img[i] = $urandom;
    img[40] = {8'hAA, 8'd50,  8'd60, 8'd7};
    img[41] = {8'h00, 8'd49,  8'd40, 8'd7};
    img[42] = {8'h00, 8'd100, 8'd20, 8'd255};
    img[43] = {8'h00, 8'd101, 8'd40, 8'd7};
    set_limits(8'd50, 8'd100, 8'd20, 8'd60, 8'd0, 8'd255);
    run_frame("limits");
    compared++;
    if (got[40] !== 32'd1 || got[41] !== 32'd0 || got[42] !== 32'd1 || got[43] !== 32'd0)
    begin
      mismatched++;
      $display("FAIL limits edges: got %0d%0d%0d%0d required 1010", got[40][0], got[41][0], got[42][0], got[43][0]);
    end
    set_limits(8'd10, 8'd5, 8'd0, 8'd255, 8'd0, 8'd255);
    run_frame("inverted");
    compared++;
    if (count !== 17'd0) begin mismatched++; $display("FAIL inverted count: got %0d required 0", count); end
  endtask

  task automatic test_border();
    for (int i = 0; i < F; i++) img[i] = 32'h00202020;
    set_limits(8'h10, 8'h30, 8'h10, 8'h30, 8'h10, 8'h30);
    run_frame("border");
    compared++;
    if (got[TOP_END-1] !== 32'd0 || got[TOP_END] !== 32'd1 || got[BOT_START-1] !== 32'd1 || got[BOT_START] !== 32'd0)
    begin
      mismatched++;
      $display("FAIL border edges: got %0d%0d%0d%0d required 0110", got[TOP_END-1][0], got[TOP_END][0], got[BOT_START-1][0], got[BOT_START][0]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < F; i++)
        img[i] = {8'($urandom), 8'($urandom_range(40, 220)), 8'($urandom_range(40, 220)), 8'($urandom_range(40, 220))};
      set_limits(8'($urandom_range(40, 100)), 8'($urandom_range(140, 220)),
                 8'($urandom_range(40, 100)), 8'($urandom_range(140, 220)),
                 8'($urandom_range(40, 100)), 8'($urandom_range(140, 220)));
      run_frame("random");
    end
  endtask

  task automatic test_drop_enable();
    int exp50;
    for (int i = 0; i < F; i++) img[i] = 32'h00FF0000;
    set_limits(8'd200, 8'd255, 8'd0, 8'd10, 8'd0, 8'd10);
    @(negedge clk); reset = 1'b0; enable = 1'b1;
    wait_write("drop", 50);
    exp50 = ref_count(50);
    @(negedge clk); enable = 1'b0;
    @(posedge clk); #1;
    check_released("drop");
    compared++;
    if (done !== 1'b0) begin mismatched++; $display("FAIL drop done: got %b required 0", done); end
    compared++;
    if (count !== 17'(exp50)) begin mismatched++; $display("FAIL drop count_held: got %0d required %0d", count, exp50); end
    repeat (2) @(posedge clk);
    @(negedge clk); enable = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (address !== 18'd0 || wren !== 1'b0 || count !== 17'd0) begin
      mismatched++;
      $display("FAIL reenable restart: got addr=%0d wren=%b count=%0d required 0/0/0", address, wren, count);
    end
    @(negedge clk); enable = 1'b0;
    @(posedge clk);
    run_frame("after_reenable");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < F; i++) img[i] = 32'h00FF0000;
    set_limits(8'd200, 8'd255, 8'd0, 8'd10, 8'd0, 8'd10);
    @(negedge clk); reset = 1'b0; enable = 1'b1;
    wait_write("midreset", 60);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check_released("midreset");
    compared++;
    if (count !== 17'd0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset state: got count=%0d done=%b required 0/0", count, done);
    end
    run_frame("after_reset");
  endtask

  initial begin
    test_reset();
    test_solid();
    test_single();
    test_limits();
    test_border();
    test_random();
    test_drop_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
